tick_count_controller: RTL
==========================

Name: tick_count_controller

Overview:
- Command-driven sequencer directly upstream of the 4-bit loadable counter; drives that counter's spe_n, te, P and rst_n inputs and consumes its TC output.
- Accepts a length command (1–16 events) over a valid/ready handshake.
- Presets the counter, gates event ticks into te, and detects the terminal tick via TC.
- Reports completion with a one-cycle done pulse and supports abort.

Parameters:
- none (width fixed at 4 to match the counter)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  command valid
- req_ready  out  1  controller can accept a command (IDLE)
- req_len  in  4  event count; 1..15 literal, 0 encodes 16
- tick_in  in  1  one-cycle event strobe to be counted
- abort  in  1  cancel the active command
- cnt_tc  in  1  TC from the counter
- cnt_rst_n  out  1  counter synchronous reset, active low
- cnt_spe_n  out  1  counter parallel load enable, active low
- cnt_te  out  1  counter count enable
- cnt_p  out  4  counter preset value
- busy  out  1  command in progress (LOAD or RUN)
- done  out  1  one-cycle pulse, command completed
- aborted  out  1  one-cycle pulse, command cancelled

Behaviour:
- Reset (async assert, sync deassert):
  - state = IDLE
  - cnt_p = 0, cnt_spe_n = 1, cnt_rst_n = 1, cnt_te = 0
  - done = 0, aborted = 0, busy = 0, req_ready = 1 (after reset deasserts)
- Preset arithmetic: cnt_p = (16 − len) mod 16, captured into a register at acceptance. Examples: len=1→15, len=5→11, len=0(16)→0.
- State IDLE:
  - req_ready = 1.
  - req_valid & req_ready at a clock edge: capture preset and go to LOAD.
  - abort in IDLE has no effect.
- State LOAD (exactly one cycle):
  - cnt_spe_n = 0, cnt_te = 0.
  - tick_in in this cycle is dropped, not counted.
  - Next state: RUN.
  - abort in LOAD goes to IDLE with an aborted pulse; the counter still loads.
- State RUN:
  - cnt_te = tick_in (combinational); cnt_spe_n = 1.
  - Terminal tick is cnt_tc = 1 in RUN. It is the len-th counted tick; on that edge the counter wraps to 0.
  - Terminal tick: next state IDLE; done = 1 for the following cycle (registered).
- Abort in RUN:
  - Next state IDLE; aborted = 1 for the following cycle.
  - cnt_rst_n = 0 for that following cycle, clearing the counter to 0.
  - If abort and terminal tick occur in the same cycle, abort wins: aborted pulses, done does not.
- busy = state is LOAD or RUN; req_ready = state is IDLE. Both are decoded from registered state.
- done and aborted never assert in the same cycle.
- Back-to-back commands: because done is registered, a new command can be accepted in the cycle done is high.
- cnt_tc asserted outside RUN is ignored.
- Latency, accept to first countable tick: 2 edges (accept edge, then LOAD edge).
- Reset mid-command: returns to IDLE immediately; no done or aborted pulse.

Optional Feature:
- Macro: TICK_CTRL_AUTO_RELOAD_EN
- Defined:
  - Adds input cfg_reload (1 bit).
  - In RUN with cfg_reload = 1, the terminal tick drives cnt_spe_n = 0 combinationally in the same cycle. Load has priority over count in the counter, so the counter reloads the captured preset instead of wrapping.
  - FSM stays in RUN, and done pulses the following cycle on each period.
  - Result: gapless periodic divide-by-len.
  - Abort still exits as normal.
  - cfg_reload = 0 behaves as in the base design.
- Undefined: no cfg_reload port; every command ends in IDLE after the terminal tick.

Test Plan:
- Reset, then no stimulus → req_ready = 1, busy = 0, cnt_spe_n = 1, cnt_te = 0, cnt_rst_n = 1, done = 0.
- req_len = 5, then tick_in every cycle → cnt_p = 11, cnt_spe_n low for exactly 1 cycle. Done pulses 1 cycle after the 5th counted tick; counter reads 0; req_ready = 1.
- req_len = 0 (16), ticks every 3rd cycle, plus one tick placed in the LOAD cycle → cnt_p = 0. LOAD tick is dropped; done follows the 16th tick counted in RUN.
- req_len = 8, abort after 3 ticks → aborted pulses once, cnt_rst_n low 1 cycle, counter = 0, no done. Repeat with abort coincident with the terminal tick → aborted only.
- Two commands: len = 2, then len = 3 issued in the done cycle → second accepted with no idle gap. Done pulses after tick 2 and after tick 5.
- With TICK_CTRL_AUTO_RELOAD_EN and cfg_reload = 1, len = 4, continuous ticks → done every 4 cycles, never returns to IDLE; abort exits to IDLE with aborted pulse.

Source files
------------

// File: rtl/tick_count_controller.sv
// tick_count_controller
// Command-driven sequencer sitting directly in front of a 4-bit loadable
// counter. Accepts a length command (1..16 events), presets the counter to
// (16 - len) mod 16, gates event ticks into the counter's count enable and
// watches its terminal-count output to detect completion.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   req_valid/req_ready    command handshake; req_ready high only in IDLE
//   req_len[3:0]           event count, 0 encodes 16
//   tick_in                one-cycle event strobe
//   abort                  cancel the active command
//   cnt_tc                 terminal count from the counter
//   cnt_rst_n              counter sync clear (registered, active low)
//   cnt_spe_n              counter parallel load (active low, state decode)
//   cnt_te                 counter count enable (tick_in gated in RUN)
//   cnt_p[3:0]             counter preset value (registered)
//   busy                   command in LOAD or RUN
//   done / aborted         one-cycle completion / cancellation pulses
//
// Build option TICK_CTRL_AUTO_RELOAD_EN adds input cfg_reload: in RUN the
// terminal tick reloads the preset instead of wrapping and the sequencer
// stays in RUN, giving a gapless periodic divide-by-len.
module tick_count_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_len,
  input  logic       tick_in,
  input  logic       abort,
  input  logic       cnt_tc,
`ifdef TICK_CTRL_AUTO_RELOAD_EN
  input  logic       cfg_reload,
`endif
  output logic       cnt_rst_n,
  output logic       cnt_spe_n,
  output logic       cnt_te,
  output logic [3:0] cnt_p,
  output logic       busy,
  output logic       done,
  output logic       aborted
);

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] preset_q, preset_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             clr_q, clr_d;
  logic             reload_c;
  logic             in_load_c;
  logic             in_run_c;

`ifdef TICK_CTRL_AUTO_RELOAD_EN
  assign reload_c = cfg_reload;
`else
  assign reload_c = 1'b0;
`endif

  assign in_load_c = (state_q == ST_LOAD);
  assign in_run_c  = (state_q == ST_RUN);

  // State and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      preset_q  <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      preset_q  <= preset_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      clr_q     <= clr_d;
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d   = state_q;
    preset_d  = preset_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    clr_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          // (16 - len) mod 16; len = 0 (meaning 16) gives preset 0
          preset_d = CNT_W'(5'd16 - 5'(req_len));
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // The counter still loads this cycle even when aborted
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort outranks a coincident terminal tick
        if (abort) begin
          aborted_d = 1'b1;
          clr_d     = 1'b1;
          state_d   = ST_IDLE;
        end else if (cnt_tc) begin
          done_d = 1'b1;
          if (!reload_c) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Counter controls; te and the reload request must act in the same cycle
  assign cnt_te    = in_run_c & tick_in;
  assign cnt_spe_n = ~(in_load_c | (in_run_c & reload_c & cnt_tc & ~abort));
  assign cnt_rst_n = ~clr_q;
  assign cnt_p     = preset_q;

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = in_load_c | in_run_c;
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule
